// File: rtl/mul_div_unit_pkg.sv
// Shared MDU/ALU definitions: flag bit positions, MDU op codes, MDU FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_div_unit_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        OP_MULU  = 3'd0,
        OP_MULHU = 3'd1,
        OP_MULS  = 3'd2,
        OP_MULHS = 3'd3,
        OP_DIVU  = 3'd4,
        OP_REMU  = 3'd5,
        OP_DIVS  = 3'd6,
        OP_REMS  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide, one result bit per clock, ALU-compatible flag word.
// Latency: WIDTH+2 cycles from accept to out_valid; divide-by-zero and MIN/-1 take 1 cycle.
// Backpressure: one op in flight; in_ready low until the result is taken; result held while out_ready low.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       flags_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags_out,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement negate, shared by operand magnitude and sign fix-up.
    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [7:0] mk_flags(input logic [3:0] hi, input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        logic [7:0] f;
        f = '0;
        f[7:4]    = hi;
        f[FLAG_C] = c;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_V] = v;
        return f;
    endfunction

    mdu_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]  opnd_b;
    mdu_op_t           op_q;
    logic              res_neg, dvd_neg;
    logic [3:0]        flags_hi;
    logic [WIDTH-1:0]  result_q;
    logic [7:0]        flags_q;
    logic              out_valid_q;

    // Accept-side decode
    mdu_op_t          op_in;
    logic             in_signed, in_div, in_rem, a_neg, b_neg, div_zero, div_ovf, special, accept;
    logic [WIDTH-1:0] a_mag, b_mag, spec_res;
    logic             unused_flags;

    assign op_in     = mdu_op_t'(op);
    assign in_signed = (op_in == OP_MULS) || (op_in == OP_MULHS) || (op_in == OP_DIVS) || (op_in == OP_REMS);
    assign in_div    = (op_in == OP_DIVU) || (op_in == OP_REMU) || (op_in == OP_DIVS) || (op_in == OP_REMS);
    assign in_rem    = (op_in == OP_REMU) || (op_in == OP_REMS);
    assign a_neg     = in_signed & a[WIDTH-1];
    assign b_neg     = in_signed & b[WIDTH-1];
    assign a_mag     = WIDTH'(negate({{WIDTH{1'b0}}, a}, a_neg));
    assign b_mag     = WIDTH'(negate({{WIDTH{1'b0}}, b}, b_neg));
    assign div_zero  = in_div && (b == '0);
    assign div_ovf   = ((op_in == OP_DIVS) || (op_in == OP_REMS)) && (a == MIN_VAL) && (b == '1);
    assign special   = div_zero | div_ovf;
    assign spec_res  = div_zero ? (in_rem ? a : '1) : (in_rem ? '0 : MIN_VAL);
    assign accept    = (state == ST_IDLE) && in_valid;
    assign unused_flags = ^flags_in[3:0];

    // One shift-add (multiply) or restoring-subtract (divide) step
    logic             is_div_q, is_rem_q;
    logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    assign is_div_q = (op_q == OP_DIVU) || (op_q == OP_REMU) || (op_q == OP_DIVS) || (op_q == OP_REMS);
    assign is_rem_q = (op_q == OP_REMU) || (op_q == OP_REMS);
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opnd_b};
    assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Sign fix-up and overflow for the normal path; one negator serves all ops
    logic [2*WIDTH-1:0] fix_src, fix_val;
    logic               fix_en, fix_v;
    logic [WIDTH-1:0]   fix_res;

    // Select the value to sign-correct and derive result and V from it
    always_comb begin
        fix_src = acc;
        fix_en  = res_neg;
        if (is_div_q) begin
            fix_src = {{WIDTH{1'b0}}, (is_rem_q ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0])};
            fix_en  = is_rem_q ? dvd_neg : res_neg;
        end
        fix_val = negate(fix_src, fix_en);
        fix_res = fix_val[WIDTH-1:0];
        fix_v   = 1'b0;
        case (op_q)
            OP_MULU:            fix_v   = |acc[2*WIDTH-1:WIDTH];
            OP_MULS:            fix_v   = (fix_val[2*WIDTH-1:WIDTH] != {WIDTH{fix_val[WIDTH-1]}});
            OP_MULHU, OP_MULHS: fix_res = fix_val[2*WIDTH-1:WIDTH];
            default:            ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = special ? ST_DONE : ST_CALC;
            end
            ST_CALC: if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: if (out_valid_q && out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture, iterate, fix up, and hold the registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            opnd_b      <= '0;
            op_q        <= OP_MULU;
            res_neg     <= 1'b0;
            dvd_neg     <= 1'b0;
            flags_hi    <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // out_valid trails DONE entry by one register stage and drops on handshake
            out_valid_q <= (state == ST_DONE) && !(out_valid_q && out_ready);
            if (accept) begin
                op_q     <= op_in;
                flags_hi <= flags_in[7:4];
                res_neg  <= a_neg ^ b_neg;
                dvd_neg  <= a_neg;
                acc      <= {{WIDTH{1'b0}}, a_mag};
                opnd_b   <= b_mag;
                cnt      <= CNT_W'(WIDTH);
                if (special) begin
                    result_q <= spec_res;
                    flags_q  <= mk_flags(flags_in[7:4], spec_res, div_zero, div_ovf);
                end
            end else if (state == ST_CALC) begin
                acc <= is_div_q ? div_next : mul_next;
                cnt <= cnt - CNT_W'(1);
            end else if (state == ST_FIX) begin
                result_q <= fix_res;
                flags_q  <= mk_flags(flags_hi, fix_res, 1'b0, fix_v);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): randomized ops vs. arithmetic reference model.
// Latency: checks WIDTH+2 normal and 1-cycle special-case result timing.
// Backpressure: random and forced out_ready stalls; scoreboard queue decouples stimulus from checking.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [7:0]  flags_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [7:0]  flags_out;
    logic        busy;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags_out(flags_out), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [7:0]  fl;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rdy_mode = 0;   // 0 random, 1 forced low, 2 forced high

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model straight from the arithmetic definitions
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [7:0] f);
        exp_t e;
        logic [63:0] pu;
        longint      ps;
        logic signed [31:0] sx, sy;
        logic [31:0] r;
        logic        c, v;
        sx = x; sy = y;
        pu = {32'b0, x} * {32'b0, y};
        ps = longint'(sx) * longint'(sy);
        c = 1'b0; v = 1'b0; e.lat = 34;
        case (o)
            3'd0: begin r = pu[31:0]; v = (pu[63:32] != 0); end
            3'd1: r = pu[63:32];
            3'd2: begin r = ps[31:0]; v = (ps > 64'sd2147483647) || (ps < -64'sd2147483648); end
            3'd3: r = ps[63:32];
            3'd4: if (y == 0) begin r = 32'hFFFFFFFF; c = 1'b1; e.lat = 1; end else r = x / y;
            3'd5: if (y == 0) begin r = x; c = 1'b1; e.lat = 1; end else r = x % y;
            3'd6: if (y == 0) begin r = 32'hFFFFFFFF; c = 1'b1; e.lat = 1; end
                  else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin r = x; v = 1'b1; e.lat = 1; end
                  else r = sx / sy;
            default: if (y == 0) begin r = x; c = 1'b1; e.lat = 1; end
                  else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin r = 0; v = 1'b1; e.lat = 1; end
                  else r = sx % sy;
        endcase
        e.res   = r;
        e.fl    = {f[7:4], v, r[31], (r == 0), c};
        e.t_acc = 0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Present one request, wait for acceptance, push its expected response
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [7:0] f);
        exp_t e;
        int w = 0;
        while (!in_ready && w < 300) begin @(posedge clk); #1; w++; end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL issue_wait: in_ready stayed %b, required 1 within 300 cycles", in_ready);
            return;
        end
        op = o; a = x; b = y; flags_in = f; in_valid = 1'b1;
        @(posedge clk); #1;
        e = model(o, x, y, f);
        e.t_acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom; flags_in = 8'($urandom);
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: out_ready = 1'b0;
                2: out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pop on rising out_valid, check timing, value stability and handshake effects
    initial begin
        exp_t cur;
        bit have = 0;
        bit was_valid = 0;
        bit expect_idle = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 0; was_valid = 0; expect_idle = 0;
            end else if (out_valid) begin
                if (!was_valid) begin
                    if (sb.size() == 0) begin
                        total++; bad++; have = 0;
                        $display("FAIL unexpected_result: got %h with no request outstanding", result);
                    end else begin
                        cur = sb.pop_front();
                        have = 1;
                        chk("latency", 32'(cyc - cur.t_acc), 32'(cur.lat));
                    end
                end
                if (have) begin
                    chk("result", result, cur.res);
                    chk("flags_out", {24'b0, flags_out}, {24'b0, cur.fl});
                end
                chk("in_ready_while_valid", {31'b0, in_ready}, 32'd0);
                expect_idle = out_ready;
                was_valid   = !out_ready;
            end else begin
                if (expect_idle) begin
                    chk("in_ready_after_take", {31'b0, in_ready}, 32'd1);
                    chk("busy_after_take", {31'b0, busy}, 32'd0);
                end
                expect_idle = 0;
                was_valid   = 0;
            end
        end
    end

    // Stimulus
    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; flags_in = '0;
        #12;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {24'b0, flags_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hA5);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h50);
        issue(3'd2, 32'hFFFFFFFD, 32'd7, 8'h00);
        issue(3'd3, 32'hFFFFFFFD, 32'd7, 8'hF0);
        issue(3'd6, 32'hFFFFFFF9, 32'd2, 8'h00);
        issue(3'd7, 32'hFFFFFFF9, 32'd2, 8'h00);
        issue(3'd4, 32'd100, 32'd7, 8'h00);
        issue(3'd5, 32'd100, 32'd7, 8'h00);
        issue(3'd4, 32'd5, 32'd0, 8'h30);
        issue(3'd5, 32'd5, 32'd0, 8'h00);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 8'h00);
        issue(3'd7, 32'h80000000, 32'hFFFFFFFF, 8'h00);

        for (int i = 0; i < 40; i++) issue(3'($urandom_range(0, 7)), pick(), pick(), 8'($urandom));

        // Backpressure: hold out_ready low with in_valid noise while the result waits
        w = 0;
        while (!(in_ready && sb.size() == 0) && w < 500) begin @(posedge clk); #1; w++; end
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(3'd4, 32'd100, 32'd7, 8'hC0);
        w = 0;
        while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL stall_wait: out_valid stayed %b, required 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            op = 3'($urandom); a = $urandom; b = $urandom;
        end
        in_valid = 1'b0;
        rdy_mode = 2;
        w = 0;
        while (out_valid && w < 20) begin @(posedge clk); #1; w++; end
        rdy_mode = 0;

        // Reset in the middle of CALC discards the operation
        w = 0;
        while (!(in_ready && sb.size() == 0) && w < 500) begin @(posedge clk); #1; w++; end
        issue(3'd0, 32'h1234, 32'h5678, 8'h00);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midcalc_reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midcalc_reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midcalc_reset_busy", {31'b0, busy}, 32'd0);
        chk("midcalc_reset_result", result, 32'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(3'd0, 32'd6, 32'd7, 8'h00);

        w = 0;
        while (!(in_ready && sb.size() == 0) && w < 3000) begin @(posedge clk); #1; w++; end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
